// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register for the ARM core.
// Registers the decoded instruction, its operands and the current NZCV flags.
// The control fields are cleared for condition-failed instructions, hazard
// bubbles and empty ID slots, and every field is cleared on a branch flush.
// A saturating counter tracks how many instructions were annulled by their
// condition code.
module id_exe_stage_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             hazard,
    input  logic             cond_check,
    input  logic             valid_in,
    input  logic             wb_en_in,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic             b_in,
    input  logic             s_in,
    input  logic [3:0]       exe_cmd_in,
    input  logic             imm_in,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      val_rn_in,
    input  logic [31:0]      val_rm_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_imm_24_in,
    input  logic [3:0]       dest_in,
    input  logic [3:0]       src1_in,
    input  logic [3:0]       src2_in,
    input  logic [3:0]       sr_in,
    output logic             valid_out,
    output logic             wb_en_out,
    output logic             mem_r_en_out,
    output logic             mem_w_en_out,
    output logic             b_out,
    output logic             s_out,
    output logic             imm_out,
    output logic [3:0]       exe_cmd_out,
    output logic [31:0]      pc_out,
    output logic [31:0]      val_rn_out,
    output logic [31:0]      val_rm_out,
    output logic [11:0]      shift_operand_out,
    output logic [23:0]      signed_imm_24_out,
    output logic [3:0]       dest_out,
    output logic [3:0]       src1_out,
    output logic [3:0]       src2_out,
    output logic [3:0]       sr_out,
    output logic [CNT_W-1:0] squash_count
);

    // The control group is dropped when the slot is empty, when the hazard
    // unit needs a bubble, or when the condition failed. Data still loads in
    // this case so the register indices stay visible for debug.
    logic bubble;
    // Only a real instruction whose condition failed is counted. A hazard
    // stall re-presents the instruction later, so it is counted at that point.
    logic squash_hit;
    logic cnt_sat;

    assign bubble     = hazard | ~valid_in | cond_check;
    assign squash_hit = ~hazard & valid_in & cond_check;
    assign cnt_sat    = &squash_count;

    // Apply the per-edge actions in priority order: reset, freeze, flush,
    // bubble, then a normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out         <= 1'b0;
            wb_en_out         <= 1'b0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            exe_cmd_out       <= '0;
            imm_out           <= 1'b0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            sr_out            <= '0;
            squash_count      <= '0;
        end else if (!freeze) begin
            if (flush) begin
                valid_out         <= 1'b0;
                wb_en_out         <= 1'b0;
                mem_r_en_out      <= 1'b0;
                mem_w_en_out      <= 1'b0;
                b_out             <= 1'b0;
                s_out             <= 1'b0;
                exe_cmd_out       <= '0;
                imm_out           <= 1'b0;
                pc_out            <= '0;
                val_rn_out        <= '0;
                val_rm_out        <= '0;
                shift_operand_out <= '0;
                signed_imm_24_out <= '0;
                dest_out          <= '0;
                src1_out          <= '0;
                src2_out          <= '0;
                sr_out            <= '0;
            end else begin
                imm_out           <= imm_in;
                pc_out            <= pc_in;
                val_rn_out        <= val_rn_in;
                val_rm_out        <= val_rm_in;
                shift_operand_out <= shift_operand_in;
                signed_imm_24_out <= signed_imm_24_in;
                dest_out          <= dest_in;
                src1_out          <= src1_in;
                src2_out          <= src2_in;
                sr_out            <= sr_in;
                if (bubble) begin
                    valid_out    <= 1'b0;
                    wb_en_out    <= 1'b0;
                    mem_r_en_out <= 1'b0;
                    mem_w_en_out <= 1'b0;
                    b_out        <= 1'b0;
                    s_out        <= 1'b0;
                    exe_cmd_out  <= '0;
                end else begin
                    valid_out    <= 1'b1;
                    wb_en_out    <= wb_en_in;
                    mem_r_en_out <= mem_r_en_in;
                    mem_w_en_out <= mem_w_en_in;
                    b_out        <= b_in;
                    s_out        <= s_in;
                    exe_cmd_out  <= exe_cmd_in;
                end
                if (squash_hit && !cnt_sat)
                    squash_count <= squash_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg with hand-computed expectations.
module tb_id_exe_stage_reg;

    localparam int CNT_W = 4;

    logic             clk, rst, freeze, flush, hazard, cond_check, valid_in;
    logic             wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]       exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
    logic [31:0]      pc_in, val_rn_in, val_rm_in;
    logic [11:0]      shift_operand_in;
    logic [23:0]      signed_imm_24_in;
    logic             valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [3:0]       exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
    logic [31:0]      pc_out, val_rn_out, val_rm_out;
    logic [11:0]      shift_operand_out;
    logic [23:0]      signed_imm_24_out;
    logic [CNT_W-1:0] squash_count;

    int errs = 0;
    int checks = 0;

    id_exe_stage_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .cond_check(cond_check), .valid_in(valid_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .imm_in(imm_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
        .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .imm_out(imm_out),
        .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .sr_out(sr_out),
        .squash_count(squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it and report any difference.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All outputs ORed together: zero only if every field is zero.
    function automatic logic [31:0] all_or();
        return {31'd0, valid_out | wb_en_out | mem_r_en_out | mem_w_en_out | b_out |
                s_out | imm_out} | {28'd0, exe_cmd_out} | pc_out | val_rn_out |
               val_rm_out | {20'd0, shift_operand_out} | {8'd0, signed_imm_24_out} |
               {28'd0, dest_out | src1_out | src2_out | sr_out} | {28'd0, squash_count};
    endfunction

    initial begin
        // Everything high, reset low, so state is unknown until rst.
        rst = 1'b0; freeze = 1'b1; flush = 1'b1; hazard = 1'b1; cond_check = 1'b1;
        valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
        b_in = 1'b1; s_in = 1'b1; imm_in = 1'b1; exe_cmd_in = '1;
        pc_in = '1; val_rn_in = '1; val_rm_in = '1; shift_operand_in = '1;
        signed_imm_24_in = '1; dest_in = '1; src1_in = '1; src2_in = '1; sr_in = '1;

        // Async reset before the first edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_async_all", all_or(), 32'd0);
        chk("rst_async_cnt", {28'd0, squash_count}, 32'd0);
        step();
        step();
        chk("rst_held_all", all_or(), 32'd0);

        // First load after release.
        freeze = 0; flush = 0; hazard = 0; cond_check = 0; valid_in = 1;
        wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 1; b_in = 0; s_in = 1; imm_in = 1;
        exe_cmd_in = 4'h9; pc_in = 32'h0000_0040; val_rn_in = 32'hDEAD_BEEF;
        val_rm_in = 32'h1234_5678; shift_operand_in = 12'hABC; signed_imm_24_in = 24'h80_0001;
        dest_in = 4'd3; src1_in = 4'd7; src2_in = 4'd12; sr_in = 4'b1010;
        #1 rst = 1'b0;
        step();
        chk("load_valid", {31'd0, valid_out}, 32'd1);
        chk("load_ctrl", {26'd0, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out}, 32'b101011);
        chk("load_cmd", {28'd0, exe_cmd_out}, 32'h9);
        chk("load_pc", pc_out, 32'h40);
        chk("load_rn", val_rn_out, 32'hDEAD_BEEF);
        chk("load_rm", val_rm_out, 32'h1234_5678);
        chk("load_shift", {20'd0, shift_operand_out}, 32'hABC);
        chk("load_imm24", {8'd0, signed_imm_24_out}, 32'h80_0001);
        chk("load_regs", {20'd0, dest_out, src1_out, src2_out}, 32'h37C);
        chk("load_sr", {28'd0, sr_out}, 32'hA);
        chk("load_cnt", {28'd0, squash_count}, 32'd0);

        // Condition annul.
        wb_en_in = 1; mem_w_en_in = 1; exe_cmd_in = 4'b0010; dest_in = 4'd5;
        sr_in = 4'b0100; valid_in = 1; cond_check = 1;
        step();
        chk("annul_wb", {31'd0, wb_en_out}, 32'd0);
        chk("annul_memw", {31'd0, mem_w_en_out}, 32'd0);
        chk("annul_cmd", {28'd0, exe_cmd_out}, 32'd0);
        chk("annul_valid", {31'd0, valid_out}, 32'd0);
        chk("annul_dest", {28'd0, dest_out}, 32'd5);
        chk("annul_sr", {28'd0, sr_out}, 32'b0100);
        chk("annul_cnt", {28'd0, squash_count}, 32'd1);

        // Freeze has priority over flush and cond_check.
        cond_check = 0; pc_in = 32'h100;
        step();
        chk("frz_pre_pc", pc_out, 32'h100);
        freeze = 1; flush = 1; cond_check = 1; pc_in = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_pc", pc_out, 32'h100);
            chk("frz_valid", {31'd0, valid_out}, 32'd1);
            chk("frz_cnt", {28'd0, squash_count}, 32'd1);
        end
        freeze = 0;
        step();
        chk("flush_pc", pc_out, 32'd0);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_sr", {28'd0, sr_out}, 32'd0);
        chk("flush_rn", val_rn_out, 32'd0);
        chk("flush_cnt", {28'd0, squash_count}, 32'd1);

        // Hazard bubble with failing condition: no count.
        flush = 0; hazard = 1; cond_check = 1; valid_in = 1; wb_en_in = 1; dest_in = 4'd9;
        step();
        chk("haz_wb", {31'd0, wb_en_out}, 32'd0);
        chk("haz_dest", {28'd0, dest_out}, 32'd9);
        chk("haz_cnt", {28'd0, squash_count}, 32'd1);
        hazard = 0; cond_check = 0;
        step();
        chk("haz_rel_wb", {31'd0, wb_en_out}, 32'd1);
        chk("haz_rel_valid", {31'd0, valid_out}, 32'd1);

        // Empty slot with failing condition: bubble, no count.
        valid_in = 0; cond_check = 1;
        step();
        chk("empty_valid", {31'd0, valid_out}, 32'd0);
        chk("empty_cnt", {28'd0, squash_count}, 32'd1);

        // Flush beats hazard.
        valid_in = 1; cond_check = 0; flush = 1; hazard = 1;
        step();
        chk("kill_pc", pc_out, 32'd0);
        chk("kill_dest", {28'd0, dest_out}, 32'd0);
        flush = 0; hazard = 0;

        // Bring counter to 7 with valid_out=1, then reset between edges.
        cond_check = 1;
        for (int i = 0; i < 6; i++) step();
        cond_check = 0;
        step();
        chk("pre_rst_cnt", {28'd0, squash_count}, 32'd7);
        chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_all", all_or(), 32'd0);
        #1 rst = 1'b0;

        // Saturation from zero.
        cond_check = 1; valid_in = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat_14", {28'd0, squash_count}, 32'd14);
            if (i == 15) chk("sat_15", {28'd0, squash_count}, 32'd15);
        end
        chk("sat_20", {28'd0, squash_count}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
